// File: rtl/jk_pkg.sv
// Shared types and per-bit JK excitation rule for the JK bank write controller.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    WAIT,
    DONE
  } jk_state_t;

  localparam logic JK_MODE_FORCE  = 1'b0;
  localparam logic JK_MODE_TOGGLE = 1'b1;

  // Returns {j, k} for one bit. FORCE never produces 11; TOGGLE pulses 11 only where the bit must flip.
  function automatic logic [1:0] jk_excite(input logic c, input logic t, input logic mode);
    logic flip;
    flip = c ^ t;
    if (mode == JK_MODE_TOGGLE) begin
      return {flip, flip};
    end
    return {t, ~t};
  endfunction

endpackage

// File: rtl/jk_bank_writer.sv
// Write-side controller for a JK flip-flop bank: one-cycle excitation drive,
// settle wait, then Q read-back compared against the requested target.
module jk_bank_writer
  import jk_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  input  logic             req_mode,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             done,
  output logic             mismatch,
  output logic [WIDTH-1:0] err_mask
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  generate
    if (SETTLE < 1) begin : g_bad_settle
      $error("jk_bank_writer: SETTLE must be >= 1");
    end
  endgenerate

  jk_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] j_next;
  logic [WIDTH-1:0] k_next;
  logic [WIDTH-1:0] diff;

  always_comb begin
    j_next = '0;
    k_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {j_next[i], k_next[i]} = jk_excite(q_fb[i], req_target[i], req_mode);
    end
  end

  assign diff = q_fb ^ target_q;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state     <= IDLE;
      cnt       <= '0;
      target_q  <= '0;
      j         <= '0;
      k         <= '0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      err_mask  <= '0;
      req_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (req_valid && req_ready) begin
            state     <= DRIVE;
            target_q  <= req_target;
            j         <= j_next;
            k         <= k_next;
            err_mask  <= '0;
            mismatch  <= 1'b0;
            req_ready <= 1'b0;
          end
        end
        DRIVE: begin
          // The bank captures j/k at this edge; release them so it holds afterwards.
          j     <= '0;
          k     <= '0;
          cnt   <= CNT_W'(SETTLE - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            err_mask <= diff;
            mismatch <= |diff;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          done      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_writer.sv
// Bench for jk_bank_writer: JK bank models with stuck-at/override injection around a SETTLE=1 and a SETTLE=3 instance.
module tb_jk_bank_writer;
  import jk_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic clear_n = 1'b0;

  logic         req_valid = 1'b0, req_mode = JK_MODE_FORCE, req_ready, done, mismatch;
  logic [W-1:0] req_target = '0, q_fb, j, k, err_mask;
  logic [W-1:0] bank, stuck0 = '0, stuck1 = '0;

  logic         req_valid3 = 1'b0, req_mode3 = JK_MODE_FORCE, req_ready3, done3, mismatch3;
  logic [W-1:0] req_target3 = '0, q_fb3, j3, k3, err_mask3;
  logic [W-1:0] bank3, ovr3 = '0;
  logic         ovr_en3 = 1'b0;

  int checks = 0;
  int errors = 0;

  jk_bank_writer #(.WIDTH(W), .SETTLE(1)) dut (
    .clk(clk), .clear_n(clear_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_target(req_target), .req_mode(req_mode), .q_fb(q_fb), .j(j), .k(k),
    .done(done), .mismatch(mismatch), .err_mask(err_mask)
  );

  jk_bank_writer #(.WIDTH(W), .SETTLE(3)) dut3 (
    .clk(clk), .clear_n(clear_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_target(req_target3), .req_mode(req_mode3), .q_fb(q_fb3), .j(j3), .k(k3),
    .done(done3), .mismatch(mismatch3), .err_mask(err_mask3)
  );

  // JK bank: 00 hold, 01 reset, 10 set, 11 toggle; cleared with the bench reset.
  always @(posedge clk) begin
    if (!clear_n) begin
      bank  <= '0;
      bank3 <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        case ({j[i], k[i]})
          2'b01:   bank[i] <= 1'b0;
          2'b10:   bank[i] <= 1'b1;
          2'b11:   bank[i] <= ~bank[i];
          default: bank[i] <= bank[i];
        endcase
        case ({j3[i], k3[i]})
          2'b01:   bank3[i] <= 1'b0;
          2'b10:   bank3[i] <= 1'b1;
          2'b11:   bank3[i] <= ~bank3[i];
          default: bank3[i] <= bank3[i];
        endcase
      end
    end
  end

  assign q_fb  = (bank & ~stuck0) | stuck1;
  assign q_fb3 = ovr_en3 ? ovr3 : bank3;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers a request and returns one time unit after the accepting edge.
  task automatic accept(input logic [W-1:0] t, input logic m);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL accept_timeout ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_target = t; req_mode = m;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    step(); step();
    clear_n = 1'b1;
    step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    checks++; if (j !== 8'h00 || k !== 8'h00) begin errors++; $display("FAIL reset_jk got %h/%h want 00/00", j, k); end
    checks++; if (done !== 1'b0 || mismatch !== 1'b0) begin errors++; $display("FAIL reset_flags got done=%b mm=%b want 0 0", done, mismatch); end
    checks++; if (err_mask !== 8'h00) begin errors++; $display("FAIL reset_err got %h want 00", err_mask); end
    checks++; if (req_ready3 !== 1'b1 || j3 !== 8'h00) begin errors++; $display("FAIL reset_dut3 got ready=%b j=%h want 1 00", req_ready3, j3); end
  endtask

  task automatic test_force();
    accept(8'hA5, JK_MODE_FORCE);
    checks++; if (j !== 8'hA5 || k !== 8'h5A) begin errors++; $display("FAIL force_jk got %h/%h want a5/5a", j, k); end
    checks++; if (req_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL force_drive_ctl got ready=%b done=%b want 0 0", req_ready, done); end
    step();
    checks++; if (j !== 8'h00 || k !== 8'h00) begin errors++; $display("FAIL force_release got %h/%h want 00/00", j, k); end
    checks++; if (bank !== 8'hA5 || done !== 1'b0) begin errors++; $display("FAIL force_bank got q=%h done=%b want a5 0", bank, done); end
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL force_done got %b want 1", done); end
    checks++; if (err_mask !== 8'h00 || mismatch !== 1'b0) begin errors++; $display("FAIL force_err got %h mm=%b want 00 0", err_mask, mismatch); end
    step();
    checks++; if (done !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL force_after got done=%b ready=%b want 0 1", done, req_ready); end
  endtask

  task automatic test_toggle();
    accept(8'h3C, JK_MODE_TOGGLE);
    checks++; if (j !== 8'h99 || k !== 8'h99) begin errors++; $display("FAIL toggle_jk got %h/%h want 99/99", j, k); end
    step();
    checks++; if (bank !== 8'h3C) begin errors++; $display("FAIL toggle_bank got %h want 3c", bank); end
    step();
    checks++; if (done !== 1'b1 || mismatch !== 1'b0) begin errors++; $display("FAIL toggle_done got done=%b mm=%b want 1 0", done, mismatch); end
    step();
  endtask

  task automatic test_stuck();
    stuck0 = 8'h01;
    accept(8'hFF, JK_MODE_FORCE);
    step(); step();
    checks++; if (done !== 1'b1 || err_mask !== 8'h01 || mismatch !== 1'b1) begin errors++; $display("FAIL stuck_err got done=%b err=%h mm=%b want 1 01 1", done, err_mask, mismatch); end
    for (int n = 0; n < 3; n++) begin
      step();
      checks++; if (err_mask !== 8'h01 || mismatch !== 1'b1 || req_ready !== 1'b1) begin errors++; $display("FAIL stuck_hold%0d got err=%h mm=%b ready=%b want 01 1 1", n, err_mask, mismatch, req_ready); end
    end
    accept(8'h00, JK_MODE_FORCE);
    checks++; if (err_mask !== 8'h00 || mismatch !== 1'b0) begin errors++; $display("FAIL stuck_clear got err=%h mm=%b want 00 0", err_mask, mismatch); end
    step(); step(); step();
    stuck0 = 8'h00;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] tgt, last;
    logic         prev_ready;
    int           accepts, dones;
    tgt = 8'h00; last = 8'h00; accepts = 0; dones = 0;
    req_valid = 1'b1; req_target = tgt; req_mode = JK_MODE_FORCE;
    for (int n = 1; n <= 16; n++) begin
      prev_ready = req_ready;
      step();
      if (prev_ready === 1'b1) begin
        accepts++;
        last = tgt;
        tgt = ~tgt;
        req_target = tgt;
      end
      if (n == 16) req_valid = 1'b0;
      checks++; if (req_ready !== ((n % 4) == 0)) begin errors++; $display("FAIL b2b_ready cycle %0d got %b want %b", n, req_ready, (n % 4) == 0); end
      if (n % 4 == 1) begin
        checks++; if (j !== last) begin errors++; $display("FAIL b2b_j cycle %0d got %h want %h", n, j, last); end
      end
      if (done === 1'b1) begin
        dones++;
        checks++; if (bank !== last || err_mask !== 8'h00) begin errors++; $display("FAIL b2b_done cycle %0d got q=%h err=%h want %h 00", n, bank, err_mask, last); end
      end
    end
    req_valid = 1'b0;
    checks++; if (accepts != 4 || dones != 4) begin errors++; $display("FAIL b2b_count got acc=%0d done=%0d want 4 4", accepts, dones); end
  endtask

  task automatic test_reset_mid_drive();
    int dones;
    dones = 0;
    accept(8'hFF, JK_MODE_FORCE);
    checks++; if (j !== 8'hFF) begin errors++; $display("FAIL mid_drive_j got %h want ff", j); end
    clear_n = 1'b0;
    step();
    clear_n = 1'b1;
    checks++; if (j !== 8'h00 || k !== 8'h00 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset got j=%h k=%h ready=%b want 00 00 1", j, k, req_ready); end
    for (int n = 0; n < 5; n++) begin
      if (done === 1'b1) dones++;
      step();
    end
    checks++; if (dones != 0 || err_mask !== 8'h00) begin errors++; $display("FAIL mid_reset_done got pulses=%0d err=%h want 0 00", dones, err_mask); end
  endtask

  task automatic test_random();
    logic [W-1:0] t, qb, ej, ek;
    logic         m;
    for (int n = 0; n < 12; n++) begin
      t  = W'($urandom);
      m  = 1'($urandom_range(0, 1));
      qb = q_fb;
      ej = (m == JK_MODE_TOGGLE) ? (qb ^ t) : t;
      ek = (m == JK_MODE_TOGGLE) ? (qb ^ t) : ~t;
      accept(t, m);
      checks++; if (j !== ej || k !== ek) begin errors++; $display("FAIL rand%0d_jk got %h/%h want %h/%h", n, j, k, ej, ek); end
      step(); step();
      checks++; if (done !== 1'b1 || bank !== t || mismatch !== 1'b0) begin errors++; $display("FAIL rand%0d_done got done=%b q=%h mm=%b want 1 %h 0", n, done, bank, mismatch, t); end
      step();
    end
  endtask

  task automatic test_settle3();
    req_valid3 = 1'b1; req_target3 = 8'h0F; req_mode3 = JK_MODE_FORCE;
    step();
    req_valid3 = 1'b0;
    checks++; if (j3 !== 8'h0F || k3 !== 8'hF0 || done3 !== 1'b0) begin errors++; $display("FAIL s3_drive got %h/%h done=%b want 0f/f0 0", j3, k3, done3); end
    step();
    checks++; if (bank3 !== 8'h0F || done3 !== 1'b0) begin errors++; $display("FAIL s3_e1 got q=%h done=%b want 0f 0", bank3, done3); end
    ovr_en3 = 1'b1; ovr3 = 8'hAA;
    step();
    checks++; if (done3 !== 1'b0) begin errors++; $display("FAIL s3_e2 done got %b want 0", done3); end
    step();
    checks++; if (done3 !== 1'b0) begin errors++; $display("FAIL s3_e3 done got %b want 0", done3); end
    ovr3 = 8'h55;
    step();
    checks++; if (done3 !== 1'b1 || err_mask3 !== 8'h5A || mismatch3 !== 1'b1) begin errors++; $display("FAIL s3_done got done=%b err=%h mm=%b want 1 5a 1", done3, err_mask3, mismatch3); end
    ovr3 = 8'hFF;
    step();
    checks++; if (done3 !== 1'b0 || err_mask3 !== 8'h5A || req_ready3 !== 1'b1) begin errors++; $display("FAIL s3_after got done=%b err=%h ready=%b want 0 5a 1", done3, err_mask3, req_ready3); end
    ovr_en3 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_force();
    test_toggle();
    test_stuck();
    test_back_to_back();
    test_reset_mid_drive();
    test_random();
    test_settle3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
